// File: rtl/store_rmw_unit.sv
// Store unit for a word-wide data memory without byte enables: sub-word stores
// read the target word, merge the byte/halfword lane and write the whole word back.
module store_rmw_unit #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  store_option,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  input  logic [31:0] mem_rdata,
  output logic        mem_we,
  output logic [31:0] mem_wdata
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WAIT,
    WR,
    DONE
  } state_t;

  state_t             state;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic [1:0]         opt_q;
  logic [31:0]        rd_q;
  logic [CNT_W-1:0]   cnt;

  // Illegal encoding, or the access is not naturally aligned for its size.
  function automatic logic is_fault(input logic [1:0] opt, input logic [1:0] lane);
    return (opt == 2'b11) ||
           (opt == 2'b01 && lane[0]) ||
           (opt == 2'b10 && lane != 2'b00);
  endfunction

  function automatic logic [31:0] merge_word(input logic [1:0]  opt,
                                             input logic [1:0]  lane,
                                             input logic [31:0] old,
                                             input logic [31:0] wd);
    logic [31:0] w;
    w = old;
    case (opt)
      2'b00:   w[{lane, 3'b000} +: 8]     = wd[7:0];
      2'b01:   w[{lane[1], 4'b0000} +: 16] = wd[15:0];
      default: w = wd;
    endcase
    return w;
  endfunction

  // Address and write data are decoded from the latched request so they only
  // appear on the memory port during the access states.
  assign mem_addr  = (state == RD || state == WAIT || state == WR) ?
                     {addr_q[31:2], 2'b00} : 32'd0;
  assign mem_wdata = mem_we ? merge_word(opt_q, addr_q[1:0], rd_q, wdata_q) : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      fault   <= 1'b0;
      mem_re  <= 1'b0;
      mem_we  <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      opt_q   <= 2'b00;
      rd_q    <= 32'd0;
      cnt     <= '0;
    end else begin
      done   <= 1'b0;
      fault  <= 1'b0;
      mem_re <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            opt_q   <= store_option;
            busy    <= 1'b1;
            if (is_fault(store_option, addr[1:0])) begin
              state <= DONE;
              done  <= 1'b1;
              fault <= 1'b1;
            end else if (store_option == 2'b10) begin
              state  <= WR;
              mem_we <= 1'b1;
            end else begin
              state  <= RD;
              mem_re <= 1'b1;
            end
          end
        end
        RD: begin
          state <= WAIT;
          cnt   <= CNT_W'(RD_LAT - 1);
        end
        // Read data is valid in the cycle the counter reaches zero.
        WAIT: begin
          if (cnt == '0) begin
            rd_q   <= mem_rdata;
            state  <= WR;
            mem_we <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        WR: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/store_rmw_unit.md
Name: store_rmw_unit

Overview:
- Store-side counterpart of the load-extension path.
- Performs sb/sh/sw into a word-wide data memory that has no byte enables, using a read-modify-write sequence for sub-word stores.
- Sits between the multi-cycle control unit (start/done handshake) and the data memory port.
- Latches the request, reads the target word if needed, merges the byte/halfword lane, writes back, and flags misaligned or illegal stores.

Parameters:
- RD_LAT, 1, memory read latency in cycles (≥1): mem_rdata is valid RD_LAT cycles after the cycle in which mem_re=1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request strobe; sampled only in IDLE.
- store_option  in  2  00=sb, 01=sh, 10=sw, 11=illegal.
- addr  in  32  byte address of the store.
- wdata  in  32  store data (rt); sb uses [7:0], sh uses [15:0].
- busy  out  1  high whenever state≠IDLE.
- done  out  1  one-cycle completion pulse.
- fault  out  1  valid with done; 1 = misaligned or illegal, no write performed.
- mem_addr  out  32  word address {addr_q[31:2],2'b00}; 0 in IDLE.
- mem_re  out  1  read strobe, one cycle.
- mem_rdata  in  32  read data from memory.
- mem_we  out  1  write strobe, one cycle.
- mem_wdata  out  32  merged write word; 0 when mem_we=0.

Behaviour:
- Reset (sync, rst=1 at a rising edge): state=IDLE; busy, done, fault, mem_re, mem_we = 0; mem_addr, mem_wdata = 0; internal registers cleared. Reset during any state aborts the operation. A write is never issued after reset is sampled; a WR cycle already in progress completes in that same cycle only.
- States: IDLE, RD, WAIT, WR, DONE.
- IDLE:
  - On start=1, latch addr_q, wdata_q, opt_q.
  - If opt_q=11, or sh with addr[0]=1, or sw with addr[1:0]≠00, go to DONE with fault=1.
  - Otherwise, sw goes to WR; sb/sh go to RD.
  - start while busy is ignored; no queueing.
- RD: mem_re=1 for one cycle; mem_addr valid. Go to WAIT with counter=RD_LAT-1.
- WAIT: counter decrements each cycle. When counter=0, capture mem_rdata into rd_q and go to WR. With RD_LAT=1, WAIT lasts exactly one cycle.
- WR:
  - mem_we=1 for one cycle; mem_wdata=merge.
  - merge for sb: rd_q with lane k=addr_q[1:0] (bits 8k+7:8k) replaced by wdata_q[7:0].
  - merge for sh: rd_q with [15:0] (addr_q[1]=0) or [31:16] (addr_q[1]=1) replaced by wdata_q[15:0].
  - merge for sw: wdata_q.
  - Go to DONE.
- DONE: done=1 for one cycle; fault held from the decision. Return to IDLE. fault is 0 whenever done=0.
- Latency (start sampled at edge of cycle t0):
  - sw: WR at t1, done at t2.
  - sb/sh: RD at t1, WR at t2+RD_LAT, done at t3+RD_LAT.
  - fault: done at t1.
- mem_addr holds the word address from RD through WR; in DONE it may hold or be 0 (don't-care); in IDLE it is 0.
- Inputs are don't-care after the start cycle; the request is taken from latched copies only.
- Back-to-back: start may be asserted in the cycle after done (IDLE) and is accepted.

Test Plan:
- sw, addr=0x100, wdata=0xDEADBEEF -> mem_we=1 at t1 with mem_addr=0x100, mem_wdata=0xDEADBEEF; done=1, fault=0 at t2; mem_re never asserted.
- sb, addr=0x103, wdata=0x000000AB, memory word 0x11223344, RD_LAT=1 -> mem_re at t1 addr 0x100; mem_we at t3 with 0xAB223344; done at t4.
- sh, addr=0x202, wdata=0x0000CAFE, memory 0x11223344 -> write 0xCAFE3344. sh, addr=0x200 -> write 0x1122CAFE. sb lanes 0/1/2 each replace only their byte.
- Faults:
  - sh addr=0x201 -> done=1, fault=1 at t1, no mem_re/mem_we.
  - sw addr=0x102 -> same.
  - store_option=11 -> same.
- start held high during busy, plus RD_LAT=3 -> second start ignored; WR at t5, done at t6; exactly one write.
- rst asserted in WAIT -> next cycle busy=0, mem_we never pulses. A new sb request afterwards completes normally.
